// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multi-cycle controller: state encoding, opcodes, datapath select encodings.
// The per-state Moore control table lives here so the FSM and its reset path use one definition.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_JAL    = 4'd10,
        S_TRAP   = 4'd11
    } state_e;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [2:0] {
        CLS_LD, CLS_SD, CLS_R, CLS_I, CLS_BEQ, CLS_JAL, CLS_ILL
    } op_class_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    // pc_write here is only the JAL strobe; the fetch-time pc_write depends on mem_ready.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src_a;
        logic       reg_write;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic [1:0] mem_to_reg;
        logic       illegal;
    } ctl_t;

    function automatic ctl_t state_ctl(input state_e s);
        ctl_t c;
        c = '0;
        c.alu_src_b  = SRCB_REG;
        c.alu_op     = ALUOP_ADD;
        c.pc_source  = PCSRC_ALU;
        c.mem_to_reg = M2R_ALU;
        case (s)
            S_FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = SRCB_FOUR; end
            S_DECODE: c.alu_src_b = SRCB_BOFF;
            S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; end
            S_MEMRD:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
            S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = M2R_MEM; end
            S_MEMWR:  begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
            S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = ALUOP_FUNCT; end
            S_IMMEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_op = ALUOP_IMM; end
            S_ALUWB:  c.reg_write = 1'b1;
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
            end
            S_JAL: begin
                c.pc_write   = 1'b1;
                c.pc_source  = PCSRC_JUMP;
                c.reg_write  = 1'b1;
                c.mem_to_reg = M2R_PC;
            end
            S_TRAP:   c.illegal = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode classifier: maps a 7-bit opcode to an instruction class.
// Anything outside the supported set is flagged illegal.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output op_class_e  op_class_o,
    output logic       illegal_o
);

    always_comb begin
        op_class_o = CLS_ILL;
        case (opcode_i)
            OP_LD:   op_class_o = CLS_LD;
            OP_SD:   op_class_o = CLS_SD;
            OP_R:    op_class_o = CLS_R;
            OP_I:    op_class_o = CLS_I;
            OP_BEQ:  op_class_o = CLS_BEQ;
            OP_JAL:  op_class_o = CLS_JAL;
            default: op_class_o = CLS_ILL;
        endcase
        illegal_o = (op_class_o == CLS_ILL);
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle processor control FSM; Moore outputs registered from next state, except the
// fetch-completion strobes (ir_write, pc_write in FETCH) which follow mem_ready combinationally.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int TRAP_STICKY   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       alu_src_a,
    output logic       reg_write,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [1:0] mem_to_reg,
    output logic       illegal,
    output logic [3:0] state
);

    state_e    state_q, state_d;
    ctl_t      ctl_q, ctl_d, ctl_out;
    op_class_e op_class;
    logic      op_illegal;
    logic      rdy_eff;
    logic      fetch_done;

    mc_ctrl_decode u_decode (
        .opcode_i   (opcode),
        .op_class_o (op_class),
        .illegal_o  (op_illegal)
    );

    assign rdy_eff = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = rdy_eff ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (op_illegal) begin
                    state_d = S_TRAP;
                end else begin
                    case (op_class)
                        CLS_LD, CLS_SD: state_d = S_MEMADR;
                        CLS_R:          state_d = S_EXEC;
                        CLS_I:          state_d = S_IMMEX;
                        CLS_BEQ:        state_d = S_BRANCH;
                        CLS_JAL:        state_d = S_JAL;
                        default:        state_d = S_TRAP;
                    endcase
                end
            end
            S_MEMADR: state_d = (op_class == CLS_LD) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = rdy_eff ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = rdy_eff ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_IMMEX:  state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JAL:    state_d = S_FETCH;
            S_TRAP:   state_d = (TRAP_STICKY != 0) ? S_TRAP : S_FETCH;
            default:  state_d = S_FETCH;
        endcase
        ctl_d = state_ctl(state_d);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
            ctl_q   <= state_ctl(S_FETCH);
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
        end
    end

    // While rst is low the outputs present FETCH immediately, even before the reset edge lands.
    assign ctl_out    = rst ? ctl_q : state_ctl(S_FETCH);
    assign fetch_done = rst && (state_q == S_FETCH) && rdy_eff;

    assign pc_write      = ctl_out.pc_write | fetch_done;
    assign ir_write      = fetch_done;
    assign pc_write_cond = ctl_out.pc_write_cond;
    assign i_or_d        = ctl_out.i_or_d;
    assign mem_read      = ctl_out.mem_read;
    assign mem_write     = ctl_out.mem_write;
    assign alu_src_a     = ctl_out.alu_src_a;
    assign reg_write     = ctl_out.reg_write;
    assign alu_src_b     = ctl_out.alu_src_b;
    assign alu_op        = ctl_out.alu_op;
    assign pc_source     = ctl_out.pc_source;
    assign mem_to_reg    = ctl_out.mem_to_reg;
    assign illegal       = ctl_out.illegal;
    assign state         = rst ? state_q : S_FETCH;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: u_a uses default parameters, u_b has MEM_HANDSHAKE=0, TRAP_STICKY=0.
// Stimulus pushes the expected output vector per cycle; a negedge monitor pops and compares.
module tb_mc_ctrl;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       mem_ready;

    logic       a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_asa, a_rw, a_ill;
    logic [1:0] a_asb, a_aop, a_pcs, a_m2r;
    logic [3:0] a_st;
    logic       b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_asa, b_rw, b_ill;
    logic [1:0] b_asb, b_aop, b_pcs, b_m2r;
    logic [3:0] b_st;

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] SD  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IA  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    mc_ctrl u_a (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(a_pcw), .pc_write_cond(a_pcwc), .i_or_d(a_iord), .mem_read(a_mrd),
        .mem_write(a_mwr), .ir_write(a_irw), .alu_src_a(a_asa), .reg_write(a_rw),
        .alu_src_b(a_asb), .alu_op(a_aop), .pc_source(a_pcs), .mem_to_reg(a_m2r),
        .illegal(a_ill), .state(a_st)
    );

    mc_ctrl #(.MEM_HANDSHAKE(0), .TRAP_STICKY(0)) u_b (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(b_pcw), .pc_write_cond(b_pcwc), .i_or_d(b_iord), .mem_read(b_mrd),
        .mem_write(b_mwr), .ir_write(b_irw), .alu_src_a(b_asa), .reg_write(b_rw),
        .alu_src_b(b_asb), .alu_op(b_aop), .pc_source(b_pcs), .mem_to_reg(b_m2r),
        .illegal(b_ill), .state(b_st)
    );

    logic [20:0] vec_a, vec_b;
    assign vec_a = {a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_asa, a_rw,
                    a_asb, a_aop, a_pcs, a_m2r, a_ill, a_st};
    assign vec_b = {b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_asa, b_rw,
                    b_asb, b_aop, b_pcs, b_m2r, b_ill, b_st};

    typedef struct {
        int          dut;
        string       nm;
        logic [20:0] v;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs straight from the per-state output table of the controller description.
    function automatic logic [20:0] golden(input logic [3:0] st, input logic rdy);
        logic pcw, pcwc, iord, mrd, mwr, irw, asa, rw, ill;
        logic [1:0] asb, aop, pcs, m2r;
        {pcw, pcwc, iord, mrd, mwr, irw, asa, rw, ill} = '0;
        {asb, aop, pcs, m2r} = '0;
        case (st)
            4'd0:  begin mrd = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            4'd1:  asb = 2'b11;
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mrd = 1; iord = 1; end
            4'd4:  begin rw = 1; m2r = 2'b01; end
            4'd5:  begin mwr = 1; iord = 1; end
            4'd6:  begin asa = 1; aop = 2'b10; end
            4'd7:  rw = 1;
            4'd8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            4'd9:  begin asa = 1; asb = 2'b10; aop = 2'b11; end
            4'd10: begin pcw = 1; pcs = 2'b10; rw = 1; m2r = 2'b10; end
            4'd11: ill = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, asa, rw, asb, aop, pcs, m2r, ill, st};
    endfunction

    // One cycle: apply inputs just after the edge and queue what the selected DUT must show.
    task automatic step(input int dut, input logic [6:0] op, input logic rdy, input logic rstv,
                        input logic [3:0] est, input string nm);
        exp_t e;
        logic rdy_eff;
        @(posedge clk);
        #2;
        opcode    = op;
        mem_ready = rdy;
        rst       = rstv;
        rdy_eff   = (dut == 1) ? 1'b1 : rdy;
        if (!rstv) rdy_eff = 1'b0;
        e.dut = dut;
        e.nm  = nm;
        e.v   = golden(rstv ? est : 4'd0, rdy_eff);
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            logic [20:0] act;
            e   = sb_q.pop_front();
            act = (e.dut == 0) ? vec_a : vec_b;
            n_cmp++;
            if (act !== e.v) begin
                n_mis++;
                $display("FAIL %s (dut %0d): got %h, required %h", e.nm, e.dut, act, e.v);
            end
        end
    end

    initial begin
        rst = 1'b0; opcode = RT; mem_ready = 1'b1;
        step(0, RT, 1, 0, 0, "reset_a0");
        step(0, RT, 1, 0, 0, "reset_a1");
        // R-type
        step(0, RT, 1, 1, 0,  "r_fetch");
        step(0, RT, 1, 1, 1,  "r_decode");
        step(0, RT, 1, 1, 6,  "r_exec");
        step(0, RT, 1, 1, 7,  "r_aluwb");
        // LD with three-cycle fetch stall
        step(0, LD, 0, 1, 0,  "ld_stall0");
        step(0, LD, 0, 1, 0,  "ld_stall1");
        step(0, LD, 0, 1, 0,  "ld_stall2");
        step(0, LD, 1, 1, 0,  "ld_fetch");
        step(0, LD, 1, 1, 1,  "ld_decode");
        step(0, LD, 1, 1, 2,  "ld_memadr");
        step(0, LD, 1, 1, 3,  "ld_memrd");
        step(0, LD, 1, 1, 4,  "ld_memwb");
        // SD then BEQ
        step(0, SD, 1, 1, 0,  "sd_fetch");
        step(0, SD, 1, 1, 1,  "sd_decode");
        step(0, SD, 1, 1, 2,  "sd_memadr");
        step(0, SD, 1, 1, 5,  "sd_memwr");
        step(0, BQ, 1, 1, 0,  "beq_fetch");
        step(0, BQ, 1, 1, 1,  "beq_decode");
        step(0, BQ, 1, 1, 8,  "beq_branch");
        // I-ALU
        step(0, IA, 1, 1, 0,  "i_fetch");
        step(0, IA, 1, 1, 1,  "i_decode");
        step(0, IA, 1, 1, 9,  "i_immex");
        step(0, IA, 1, 1, 7,  "i_aluwb");
        // JAL, mem_ready low in DECODE must not matter
        step(0, JL, 1, 1, 0,  "jal_fetch");
        step(0, JL, 0, 1, 1,  "jal_decode_nordy");
        step(0, JL, 0, 1, 10, "jal_jal");
        // LD with MEMRD stall
        step(0, LD, 1, 1, 0,  "ldm_fetch");
        step(0, LD, 1, 1, 1,  "ldm_decode");
        step(0, LD, 0, 1, 2,  "ldm_memadr");
        step(0, LD, 0, 1, 3,  "ldm_memrd_stall0");
        step(0, LD, 0, 1, 3,  "ldm_memrd_stall1");
        step(0, LD, 1, 1, 3,  "ldm_memrd_done");
        step(0, LD, 1, 1, 4,  "ldm_memwb");
        // SD with MEMWR stall
        step(0, SD, 1, 1, 0,  "sdm_fetch");
        step(0, SD, 1, 1, 1,  "sdm_decode");
        step(0, SD, 1, 1, 2,  "sdm_memadr");
        step(0, SD, 0, 1, 5,  "sdm_memwr_stall");
        step(0, SD, 1, 1, 5,  "sdm_memwr_done");
        // Reset during a MEMRD stall
        step(0, LD, 1, 1, 0,  "rld_fetch");
        step(0, LD, 1, 1, 1,  "rld_decode");
        step(0, LD, 1, 1, 2,  "rld_memadr");
        step(0, LD, 0, 1, 3,  "rld_memrd_stall");
        step(0, LD, 1, 0, 0,  "rld_reset");
        step(0, LD, 0, 1, 0,  "rld_after_reset");
        step(0, LD, 0, 1, 0,  "rld_no_memwb");
        // Illegal opcode, sticky trap
        step(0, BAD, 1, 1, 0,  "ill_fetch");
        step(0, BAD, 1, 1, 1,  "ill_decode");
        step(0, BAD, 1, 1, 11, "ill_trap0");
        step(0, BAD, 1, 1, 11, "ill_trap1");
        step(0, BAD, 1, 1, 11, "ill_trap2");
        step(0, BAD, 1, 0, 0,  "ill_reset");
        step(0, RT, 1, 1, 0,   "ill_after_reset");
        // Second instance: no handshake, non-sticky trap
        step(1, LD, 0, 0, 0,  "b_reset");
        step(1, LD, 0, 1, 0,  "b_ld_fetch");
        step(1, LD, 0, 1, 1,  "b_ld_decode");
        step(1, LD, 0, 1, 2,  "b_ld_memadr");
        step(1, LD, 0, 1, 3,  "b_ld_memrd");
        step(1, LD, 0, 1, 4,  "b_ld_memwb");
        step(1, SD, 0, 1, 0,  "b_sd_fetch");
        step(1, SD, 0, 1, 1,  "b_sd_decode");
        step(1, SD, 0, 1, 2,  "b_sd_memadr");
        step(1, SD, 0, 1, 5,  "b_sd_memwr");
        step(1, BAD, 0, 1, 0,  "b_ill_fetch");
        step(1, BAD, 0, 1, 1,  "b_ill_decode");
        step(1, BAD, 0, 1, 11, "b_ill_trap");
        step(1, BAD, 0, 1, 0,  "b_trap_release");
        step(1, RT, 0, 1, 1,   "b_r_decode");

        repeat (3) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
